// File: rtl/nes_loader_pkg.sv
// nes_loader shared types: command word layout, opcodes and FSM states.
package nes_loader_pkg;

  localparam int unsigned CMD_W     = 32;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned PAYLOAD_W = 24;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [OP_W-1:0] {
    OP_SET_ADDR = 8'h01,
    OP_WRITE    = 8'h02,
    OP_FILL     = 8'h03,
    OP_CTRL     = 8'h04
  } opcode_e;

  // FIFO payload type: the host FIFO carries cmd_t words
  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [PAYLOAD_W-1:0] payload;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL
  } state_e;

  // Beat count of a FILL command
  function automatic logic [CNT_W-1:0] fill_count(input cmd_t c);
    return c.payload[23:8];
  endfunction

endpackage

// File: rtl/nes_loader.sv
// nes_loader: pops host command words and turns them into PRG/CHR byte
// writes and NES reset control, all on the NES clock.
module nes_loader
  import nes_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  rdata,
  input  logic              rrdy,
  output logic              rget,
  output logic              mem_req,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              nes_rst,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  wr_count
);

  cmd_t             cmd;
  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             pop;
  logic             beat;

  assign cmd  = cmd_t'(rdata);
  assign pop  = rget;
  assign beat = mem_req && mem_ack;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: WRITE/non-empty FILL leave IDLE, last ack returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rrdy) begin
          case (cmd.op)
            OP_WRITE: state_nxt = ST_WRITE;
            OP_FILL:  if (fill_count(cmd) != '0) state_nxt = ST_FILL;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: if (mem_ack) state_nxt = ST_IDLE;
      ST_FILL:  if (mem_ack && (remaining == CNT_W'(1))) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register; pops only happen in IDLE
  always_comb begin
    rget    = 1'b0;
    mem_req = 1'b0;
    busy    = 1'b0;
    case (state)
      ST_IDLE:  rget = rrdy;
      ST_WRITE,
      ST_FILL: begin
        mem_req = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        rget    = 1'b0;
        mem_req = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

  // Datapath: command decode on pop, address/count advance on each ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_sel   <= 1'b0;
      mem_wdata <= '0;
      nes_rst   <= 1'b1;
      err       <= 1'b0;
      wr_count  <= '0;
      remaining <= '0;
    end else begin
      if (pop) begin
        case (cmd.op)
          OP_SET_ADDR: begin
            if (cmd.payload[17]) begin
              err <= 1'b1;
            end else begin
              mem_addr <= cmd.payload[ADDR_W-1:0];
              mem_sel  <= cmd.payload[16];
            end
          end
          OP_WRITE: mem_wdata <= cmd.payload[7:0];
          OP_FILL: begin
            mem_wdata <= cmd.payload[7:0];
            remaining <= fill_count(cmd);
          end
          OP_CTRL: nes_rst <= cmd.payload[0];
          default: err <= 1'b1;
        endcase
      end
      if (beat) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        if (wr_count != {CNT_W{1'b1}}) wr_count <= wr_count + CNT_W'(1);
        if (state == ST_FILL) remaining <= remaining - CNT_W'(1);
      end
    end
  end

  // Never pop an empty FIFO
  a_rget_rrdy : assert property (@(posedge clk) disable iff (reset) rget |-> rrdy);

  // Write payload holds while a request is stalled
  a_req_stable : assert property (@(posedge clk) disable iff (reset)
    (mem_req && !mem_ack) |=> ($stable(mem_addr) && $stable(mem_wdata) && $stable(mem_sel)));

endmodule

// File: tb/tb_nes_loader.sv
// tb_nes_loader: directed and randomized command streams against a
// command-level reference model of the loader.
`timescale 1ns/1ps
module tb_nes_loader;

  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       rdata;
  logic              rrdy;
  logic              rget;
  logic              mem_req;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic              nes_rst;
  logic              busy;
  logic              err;
  logic [15:0]       wr_count;

  typedef struct {
    logic        sel;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } beat_t;

  logic [31:0] fifo_q[$];
  beat_t       got_q[$];
  beat_t       exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int rget_bad = 0;
  int ack_mode = 0;
  int stall_n = 0;
  logic pend_pop = 1'b0;
  logic was_stall = 1'b0;
  logic [15:0] st_addr;
  logic [7:0]  st_data;
  logic        st_sel;

  // reference model state
  logic [15:0] m_addr;
  logic        m_sel;
  logic        m_err;
  logic        m_rst;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  nes_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rdata(rdata), .rrdy(rrdy), .rget(rget),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .nes_rst(nes_rst),
    .busy(busy), .err(err), .wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rrdy  = (fifo_q.size() != 0);
    rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_addr = 16'h0; m_sel = 1'b0; m_err = 1'b0; m_rst = 1'b1; m_cnt = 16'h0;
  endtask

  task automatic emit(input logic [7:0] d);
    beat_t b;
    b.sel = m_sel; b.addr = m_addr; b.data = d; b.cyc = 0;
    exp_q.push_back(b);
    m_addr = m_addr + 16'd1;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  // Queue one command word and apply its effect to the model
  task automatic push(input logic [31:0] w);
    logic [7:0]  op;
    logic [23:0] p;
    fifo_q.push_back(w);
    refresh();
    op = w[31:24];
    p  = w[23:0];
    case (op)
      8'h01: if (p[17]) m_err = 1'b1; else begin m_addr = p[15:0]; m_sel = p[16]; end
      8'h02: emit(p[7:0]);
      8'h03: for (int i = 0; i < int'(p[23:8]); i++) emit(p[7:0]);
      8'h04: m_rst = p[0];
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(fifo_q.size() == 0 && !busy) && n < budget) begin
      cyc();
      n++;
    end
    chk("done_in_budget", 32'(n < budget), 32'd1);
  endtask

  // Compare logged beats and architectural outputs with the model, then clear
  task automatic check_all(input string tag);
    chk({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i].sel !== exp_q[i].sel || got_q[i].addr !== exp_q[i].addr ||
          got_q[i].data !== exp_q[i].data)
        chk({tag, "_beat"}, {7'h0, got_q[i].sel, got_q[i].addr, got_q[i].data},
                            {7'h0, exp_q[i].sel, exp_q[i].addr, exp_q[i].data});
    end
    n_vec++;
    chk({tag, "_addr"}, 32'(mem_addr), 32'(m_addr));
    chk({tag, "_sel"}, 32'(mem_sel), 32'(m_sel));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_nes_rst"}, 32'(nes_rst), 32'(m_rst));
    chk({tag, "_wr_count"}, 32'(wr_count), 32'(m_cnt));
    chk({tag, "_req_idle"}, 32'(mem_req), 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  // Observe handshakes mid-cycle and check stalled payload stability
  always @(negedge clk) begin
    pend_pop = 1'b0;
    if (!reset) begin
      pend_pop = rget;
      if (rget && (busy || !rrdy)) rget_bad++;
      if (mem_req && mem_ack) begin
        beat_t b;
        b.sel = mem_sel; b.addr = mem_addr; b.data = mem_wdata; b.cyc = cyc_n;
        got_q.push_back(b);
      end
      if (was_stall && mem_req)
        chk("stall_stable", {7'h0, mem_sel, mem_addr, mem_wdata}, {7'h0, st_sel, st_addr, st_data});
      was_stall = mem_req && !mem_ack;
      st_sel = mem_sel; st_addr = mem_addr; st_data = mem_wdata;
    end else begin
      was_stall = 1'b0;
    end
  end

  // FIFO pop and mem_ack generation, just after each edge
  always @(posedge clk) begin
    cyc_n++;
    #1;
    if (pend_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
    case (ack_mode)
      0: mem_ack = 1'b1;
      1: mem_ack = ($urandom_range(0, 1) == 1);
      default: begin
        if (!mem_req) begin
          mem_ack = 1'b0; stall_n = 0;
        end else if (stall_n < 5) begin
          mem_ack = 1'b0; stall_n++;
        end else begin
          mem_ack = 1'b1; stall_n = 0;
        end
      end
    endcase
  end

  initial begin
    int gap;
    reset = 1'b1;
    mem_ack = 1'b1;
    refresh();
    model_reset();
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // reset state with empty FIFO
    chk("rst_nes_rst", 32'(nes_rst), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_rget", 32'(rget), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);

    // single writes to CHR, one byte per two cycles
    ack_mode = 0;
    push(32'h0101_8000);
    push(32'h0200_00A5);
    push(32'h0200_005A);
    wait_done(50);
    if (got_q.size() >= 2) chk("write_rate", 32'(got_q[1].cyc - got_q[0].cyc), 32'd2);
    else chk("write_rate_beats", 32'(got_q.size()), 32'd2);
    check_all("write");

    // fill across the address wrap, beats on consecutive cycles
    push(32'h0100_FFFE);
    push(32'h0300_043C);
    wait_done(50);
    if (got_q.size() >= 4) chk("fill_rate", 32'(got_q[3].cyc - got_q[0].cyc), 32'd3);
    else chk("fill_rate_beats", 32'(got_q.size()), 32'd4);
    check_all("fill_wrap");

    // fill with 5 stalled cycles on every beat
    ack_mode = 2;
    push(32'h0100_2000);
    push(32'h0300_03C7);
    wait_done(100);
    chk("stall_busy", 32'(busy), 32'd0);
    check_all("fill_stall");

    // illegal opcode and bad target: err sticks, no writes, words popped
    ack_mode = 0;
    push(32'h7F00_0000);
    push(32'h0102_1234);
    wait_done(50);
    chk("bad_popped", 32'(rrdy), 32'd0);
    check_all("bad_cmd");

    // NES reset control
    push(32'h0400_0000);
    wait_done(50);
    check_all("ctrl_release");
    push(32'h0400_0001);
    wait_done(50);
    check_all("ctrl_hold");

    // randomized command streams with random ack
    ack_mode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 12; k++) begin
        gap = $urandom_range(0, 9);
        case (gap)
          0, 1: push({8'h01, 6'h0, 1'b0, 17'($urandom)});
          2, 3, 4: push({8'h02, 16'($urandom), 8'($urandom)});
          5, 6: push({8'h03, 16'($urandom_range(0, 5)), 8'($urandom)});
          7: push({8'h04, 24'($urandom)});
          8: push({8'($urandom_range(5, 255)), 24'($urandom)});
          default: push({8'h01, 24'($urandom)});
        endcase
      end
      wait_done(1000);
      check_all("random");
    end

    // reset in the middle of a long fill
    ack_mode = 0;
    push(32'h0100_4000);
    push(32'h0300_6411);
    gap = 0;
    while (got_q.size() < 10 && gap < 200) begin
      cyc();
      gap++;
    end
    chk("midfill_reached", 32'(got_q.size()), 32'd10);
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_nes_rst", 32'(nes_rst), 32'd1);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    fifo_q.delete();
    refresh();
    got_q.delete();
    exp_q.delete();
    model_reset();
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("postrst_no_req", 32'(mem_req), 32'd0);
    push(32'h0100_1234);
    push(32'h0200_0077);
    wait_done(50);
    check_all("after_reset");

    // wr_count saturation over a maximal fill
    push(32'h03FF_FF11);
    push(32'h0200_0022);
    wait_done(70000);
    check_all("saturate");

    chk("rget_only_idle", 32'(rget_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
